// File: rtl/loop_counter_2d_if.sv
// Control and status bundle for the two-level iteration counter.
interface loop_counter_2d_if #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 8
);
  logic             start;
  logic             clear;
  logic             enable;
  logic [IN_W-1:0]  inner_max;
  logic [OUT_W-1:0] outer_max;
  logic [IN_W-1:0]  inner_cnt;
  logic [OUT_W-1:0] outer_cnt;
  logic             busy;
  logic             inner_wrap;
  logic             done;
  logic             final_filter;

  modport master (
    output start, clear, enable, inner_max, outer_max,
    input  inner_cnt, outer_cnt, busy, inner_wrap, done, final_filter
  );

  modport slave (
    input  start, clear, enable, inner_max, outer_max,
    output inner_cnt, outer_cnt, busy, inner_wrap, done, final_filter
  );
endinterface

// File: rtl/loop_counter_2d.sv
// Two-level iteration counter: inner 0..inner_lim nested in outer 0..outer_lim,
// limits latched on start, stepping on enable, with wrap/done pulses and a
// sticky final_filter flag. All outputs are registered.
module loop_counter_2d #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  loop_counter_2d_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  inner_q, inner_d;
  logic [OUT_W-1:0] outer_q, outer_d;
  logic [IN_W-1:0]  inner_lim_q, inner_lim_d;
  logic [OUT_W-1:0] outer_lim_q, outer_lim_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             ff_q, ff_d;

  // State and output registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      inner_q     <= '0;
      outer_q     <= '0;
      inner_lim_q <= '0;
      outer_lim_q <= '0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      ff_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inner_q     <= inner_d;
      outer_q     <= outer_d;
      inner_lim_q <= inner_lim_d;
      outer_lim_q <= outer_lim_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
      ff_q        <= ff_d;
    end
  end

  // Next-state logic with priority clear > start > enable.
  always_comb begin
    state_d     = state_q;
    inner_d     = inner_q;
    outer_d     = outer_q;
    inner_lim_d = inner_lim_q;
    outer_lim_d = outer_lim_q;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    ff_d        = ff_q;

    if (bus.clear) begin
      state_d = IDLE;
      inner_d = '0;
      outer_d = '0;
      busy_d  = 1'b0;
      ff_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            inner_lim_d = bus.inner_max;
            outer_lim_d = bus.outer_max;
            inner_d     = '0;
            outer_d     = '0;
            ff_d        = 1'b0;
            busy_d      = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (bus.enable) begin
            if (inner_q != inner_lim_q) begin
              inner_d = inner_q + IN_W'(1);
            end else begin
              inner_d = '0;
              wrap_d  = 1'b1;
              if (outer_q != outer_lim_q) begin
                outer_d = outer_q + OUT_W'(1);
              end else begin
                outer_d = '0;
                done_d  = 1'b1;
                ff_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.inner_cnt    = inner_q;
  assign bus.outer_cnt    = outer_q;
  assign bus.busy         = busy_q;
  assign bus.inner_wrap   = wrap_q;
  assign bus.done         = done_q;
  assign bus.final_filter = ff_q;

endmodule

// File: tb/tb_loop_counter_2d.sv
// Scoreboard bench for loop_counter_2d: a step-index reference model predicts
// every cycle's outputs, queued at drive time and compared after the edge.
module tb_loop_counter_2d;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 8;

  logic clk;
  logic reset;

  loop_counter_2d_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  loop_counter_2d #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference model: linear step index k within the run.
  bit m_run  = 0;
  int m_k    = 0;
  int m_ilim = 0;
  int m_olim = 0;
  bit m_ff   = 0;
  bit m_wrap = 0;
  bit m_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int i, input int o, input bit b,
                                       input bit w, input bit d, input bit f);
    return 32'({i[IN_W-1:0], o[OUT_W-1:0], b, w, d, f});
  endfunction

  function automatic logic [31:0] observed();
    return 32'({bus.inner_cnt, bus.outer_cnt, bus.busy, bus.inner_wrap,
                bus.done, bus.final_filter});
  endfunction

  task automatic model_step(input bit st, input bit cl, input bit en, input int im, input int om);
    m_wrap = 0;
    m_done = 0;
    if (cl) begin
      m_run = 0; m_k = 0; m_ff = 0;
    end else if (!m_run) begin
      if (st) begin
        m_ilim = im; m_olim = om; m_k = 0; m_ff = 0; m_run = 1;
      end
    end else if (en) begin
      m_k++;
      if (m_k % (m_ilim + 1) == 0) m_wrap = 1;
      if (m_k == (m_ilim + 1) * (m_olim + 1)) begin
        m_done = 1; m_ff = 1; m_run = 0; m_k = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_out();
    return pack(m_k % (m_ilim + 1), m_k / (m_ilim + 1), m_run, m_wrap, m_done, m_ff);
  endfunction

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic cyc(input string tag, input bit st, input bit cl, input bit en,
                     input int im, input int om);
    logic [31:0] e;
    bus.start     = st;
    bus.clear     = cl;
    bus.enable    = en;
    bus.inner_max = im[IN_W-1:0];
    bus.outer_max = om[OUT_W-1:0];
    model_step(st, cl, en, im, om);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, observed(), e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.enable    = 1'b0;
    bus.inner_max = '0;
    bus.outer_max = '0;
    #12;
    check_eq("reset_state", observed(), 32'd0);
    reset = 1'b1;

    // Legacy modulo-25 equivalent
    cyc("legacy_start", 1, 0, 0, 24, 0);
    for (int i = 0; i < 25; i++) cyc("legacy_run", 0, 0, 1, 24, 0);
    for (int i = 0; i < 2; i++)  cyc("legacy_sticky", 0, 0, 1, 24, 0);

    // 2D walk
    cyc("walk_start", 1, 0, 0, 2, 3);
    for (int i = 0; i < 12; i++) cyc("walk_run", 0, 0, 1, 2, 3);
    cyc("walk_after", 0, 0, 0, 2, 3);

    // Gapped enable
    cyc("gap_start", 1, 0, 0, 3, 1);
    for (int i = 0; i < 16; i++) cyc("gap_run", 0, 0, (i % 2) == 0, 3, 1);

    // Degenerate limits 0/0
    cyc("zero_start", 1, 0, 0, 0, 0);
    cyc("zero_step", 0, 0, 1, 0, 0);
    cyc("zero_after", 0, 0, 1, 0, 0);

    // Maximum limits
    cyc("max_start", 1, 0, 0, 31, 255);
    for (int i = 0; i < 8192; i++) cyc("max_run", 0, 0, 1, 31, 255);
    cyc("max_after", 0, 0, 0, 31, 255);

    // Clear mid-run, with enable also high
    cyc("clr_start", 1, 0, 0, 2, 3);
    for (int i = 0; i < 5; i++) cyc("clr_run", 0, 0, 1, 2, 3);
    cyc("clr_hit", 0, 1, 1, 2, 3);
    cyc("clr_idle", 0, 0, 1, 2, 3);

    // start+enable together in IDLE, then start and limit changes mid-run
    cyc("se_start", 1, 0, 1, 2, 3);
    cyc("se_run", 0, 0, 1, 2, 3);
    cyc("run_restart", 1, 0, 1, 7, 9);
    for (int i = 0; i < 10; i++) cyc("run_newmax", 0, 0, 1, 5, 1);
    cyc("run_after", 0, 0, 0, 5, 1);

    // Asynchronous reset between edges
    cyc("ar_start", 1, 0, 0, 2, 3);
    for (int i = 0; i < 4; i++) cyc("ar_run", 0, 0, 1, 2, 3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset", observed(), 32'd0);
    m_run = 0; m_k = 0; m_ilim = 0; m_olim = 0; m_ff = 0; m_wrap = 0; m_done = 0;
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ar_enable_only", 0, 0, 1, 2, 3);
    cyc("ar_restart", 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc("ar_run2", 0, 0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
